muldiv_alu_control: RTL and testbench

Parametrised successor to the EX-stage ALU control decode. It turns `alu_op` plus the funct field into a 4-bit ALU operation code for the single-cycle datapath. It also owns the HI/LO registers and a multi-cycle iterative multiply/divide engine. The block sits in the EX stage of the pipeline and drives `stall` to the hazard unit whenever a HI/LO-class instruction must wait for the engine.

---
 rtl/muldiv_alu_control.sv | 270 +++++++++++++++++++++++++++
 tb/tb_muldiv_alu_control.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_alu_control.sv
// muldiv_alu_control
//   EX-stage ALU control decode plus HI/LO registers and an iterative,
//   one-bit-per-cycle multiply/divide engine.
//
//   Optional feature macro: MULDIV_DIV_EN
//     defined   -> DIV/DIVU decode, restoring divider and div_by_zero present
//     undefined -> DIV/DIVU are plain ALU ADDs, div_by_zero tied 0
//
// Ports
//   clk, reset        rising-edge clock, asynchronous active-high reset
//   alu_op            main-control ALUOp
//   func_field        instruction funct field (bits [5:0] decoded)
//   valid             EX-stage instruction valid
//   operand_a/_b      rs / rt values
//   operation         4-bit ALU operation code (combinational)
//   md_result         HI for MFHI, LO otherwise (combinational, 0 in reset)
//   md_busy           engine running (registered)
//   stall             hold the EX md-class instruction (combinational)
//   div_by_zero       one-cycle registered pulse on a divide by zero
module muldiv_alu_control #(
   parameter int WIDTH  = 32,
   parameter int FUNC_W = 6
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [1:0]        alu_op,
   input  logic [FUNC_W-1:0] func_field,
   input  logic              valid,
   input  logic [WIDTH-1:0]  operand_a,
   input  logic [WIDTH-1:0]  operand_b,
   output logic [3:0]        operation,
   output logic [WIDTH-1:0]  md_result,
   output logic              md_busy,
   output logic              stall,
   output logic              div_by_zero
);

   localparam int CW = $clog2(WIDTH + 1);

   localparam logic [3:0] OP_AND  = 4'b0000;
   localparam logic [3:0] OP_OR   = 4'b0001;
   localparam logic [3:0] OP_ADD  = 4'b0010;
   localparam logic [3:0] OP_XOR  = 4'b0011;
   localparam logic [3:0] OP_SUB  = 4'b0110;
   localparam logic [3:0] OP_SLT  = 4'b0111;
   localparam logic [3:0] OP_SLTU = 4'b1000;
   localparam logic [3:0] OP_NOR  = 4'b1100;
   localparam logic [3:0] OP_MD   = 4'b1111;

   localparam logic [5:0] FN_ADD   = 6'b100000;
   localparam logic [5:0] FN_SUB   = 6'b100010;
   localparam logic [5:0] FN_AND   = 6'b100100;
   localparam logic [5:0] FN_OR    = 6'b100101;
   localparam logic [5:0] FN_XOR   = 6'b100110;
   localparam logic [5:0] FN_NOR   = 6'b100111;
   localparam logic [5:0] FN_SLT   = 6'b101010;
   localparam logic [5:0] FN_SLTU  = 6'b101011;
   localparam logic [5:0] FN_MFHI  = 6'b010000;
   localparam logic [5:0] FN_MTHI  = 6'b010001;
   localparam logic [5:0] FN_MFLO  = 6'b010010;
   localparam logic [5:0] FN_MTLO  = 6'b010011;
   localparam logic [5:0] FN_MULT  = 6'b011000;
   localparam logic [5:0] FN_MULTU = 6'b011001;
`ifdef MULDIV_DIV_EN
   localparam logic [5:0] FN_DIV   = 6'b011010;
   localparam logic [5:0] FN_DIVU  = 6'b011011;
`endif

   typedef enum logic {IDLE, RUN} state_t;

   state_t             state_q, state_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   // work register: multiply = {partial product hi, multiplier/product lo},
   // divide = {partial remainder, dividend/quotient}
   logic [2*WIDTH-1:0] work_q, work_d, step;
   logic [WIDTH-1:0]   opnd_q, opnd_d;   // multiplicand or divisor magnitude
   logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
   logic               neg_q, neg_d;     // product / quotient sign
   logic               dbz_q, dbz_d;
`ifdef MULDIV_DIV_EN
   logic               div_q, div_d;
   logic               rneg_q, rneg_d;   // remainder sign (dividend sign)
`endif

   logic [5:0]         fn;
   logic               is_r, is_mul, is_div, is_mt, is_mf, md_class, accept;
   logic               sgn, sa, sb;
   logic [WIDTH-1:0]   mag_a, mag_b;
   logic [WIDTH:0]     mul_sum;
   logic [2*WIDTH-1:0] mul_step, mul_fix;

   assign fn = func_field[5:0];

   // ---------------- ALU decode ----------------
   always_comb begin
      operation = OP_ADD;
      case (alu_op)
         2'b01: operation = OP_SUB;
         2'b10: begin
            case (fn)
               FN_ADD:           operation = OP_ADD;
               FN_SUB:           operation = OP_SUB;
               FN_AND:           operation = OP_AND;
               FN_OR:            operation = OP_OR;
               FN_XOR:           operation = OP_XOR;
               FN_NOR:           operation = OP_NOR;
               FN_SLT:           operation = OP_SLT;
               FN_SLTU:          operation = OP_SLTU;
               FN_MFHI, FN_MFLO: operation = OP_MD;
               default:          operation = OP_ADD;
            endcase
         end
         default: operation = OP_ADD;
      endcase
   end

   // ---------------- md-class classification ----------------
   assign is_r   = (alu_op == 2'b10);
   assign is_mul = is_r & ((fn == FN_MULT) | (fn == FN_MULTU));
`ifdef MULDIV_DIV_EN
   assign is_div = is_r & ((fn == FN_DIV) | (fn == FN_DIVU));
`else
   assign is_div = 1'b0;
`endif
   assign is_mt    = is_r & ((fn == FN_MTHI) | (fn == FN_MTLO));
   assign is_mf    = is_r & ((fn == FN_MFHI) | (fn == FN_MFLO));
   assign md_class = is_mul | is_div | is_mt | is_mf;

   assign md_busy = (state_q == RUN);
   assign stall   = valid & md_class & md_busy;
   assign accept  = valid & md_class & ~md_busy;

   // MULT and DIV have funct bit 0 clear; the unsigned forms have it set
   assign sgn   = ~fn[0];
   assign sa    = sgn & operand_a[WIDTH-1];
   assign sb    = sgn & operand_b[WIDTH-1];
   assign mag_a = sa ? (~operand_a + 1'b1) : operand_a;
   assign mag_b = sb ? (~operand_b + 1'b1) : operand_b;

   // ---------------- iteration step ----------------
   // shift-add: add multiplicand into the upper half when the current
   // multiplier bit is set, then shift the whole word right by one
   assign mul_sum  = {1'b0, work_q[2*WIDTH-1:WIDTH]} + (work_q[0] ? {1'b0, opnd_q} : '0);
   assign mul_step = {mul_sum, work_q[WIDTH-1:1]};
   assign mul_fix  = neg_q ? (~mul_step + 1'b1) : mul_step;

`ifdef MULDIV_DIV_EN
   logic [WIDTH:0]     div_shift, div_diff;
   logic [2*WIDTH-1:0] div_step;
   // restoring divide: bring the next dividend bit into the remainder and
   // keep the subtraction only when it does not go negative
   assign div_shift = {work_q[2*WIDTH-1:WIDTH], work_q[WIDTH-1]};
   assign div_diff  = div_shift - {1'b0, opnd_q};
   assign div_step  = div_diff[WIDTH]
                      ? {div_shift[WIDTH-1:0], work_q[WIDTH-2:0], 1'b0}
                      : {div_diff[WIDTH-1:0],  work_q[WIDTH-2:0], 1'b1};
   assign step      = div_q ? div_step : mul_step;
`else
   assign step      = mul_step;
`endif

   // ---------------- next state ----------------
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      work_d  = work_q;
      opnd_d  = opnd_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      neg_d   = neg_q;
      dbz_d   = 1'b0;
`ifdef MULDIV_DIV_EN
      div_d   = div_q;
      rneg_d  = rneg_q;
`endif
      case (state_q)
         IDLE: begin
            if (accept) begin
               if (is_mul) begin
                  work_d  = {{WIDTH{1'b0}}, mag_b};
                  opnd_d  = mag_a;
                  neg_d   = sa ^ sb;
                  cnt_d   = CW'(WIDTH);
                  state_d = RUN;
`ifdef MULDIV_DIV_EN
                  div_d   = 1'b0;
`endif
               end
`ifdef MULDIV_DIV_EN
               else if (is_div) begin
                  if (operand_b == '0) begin
                     // no iteration: fixed result written at the issue edge
                     hi_d  = operand_a;
                     lo_d  = '1;
                     dbz_d = 1'b1;
                  end else begin
                     work_d  = {{WIDTH{1'b0}}, mag_a};
                     opnd_d  = mag_b;
                     neg_d   = sa ^ sb;
                     rneg_d  = sa;
                     div_d   = 1'b1;
                     cnt_d   = CW'(WIDTH);
                     state_d = RUN;
                  end
               end
`endif
               else if (is_r && fn == FN_MTHI) begin
                  hi_d = operand_a;
               end else if (is_r && fn == FN_MTLO) begin
                  lo_d = operand_a;
               end
            end
         end
         RUN: begin
            work_d = step;
            cnt_d  = cnt_q - 1'b1;
            if (cnt_q == CW'(1)) begin
               state_d = IDLE;
`ifdef MULDIV_DIV_EN
               if (div_q) begin
                  lo_d = neg_q  ? (~step[WIDTH-1:0] + 1'b1)       : step[WIDTH-1:0];
                  hi_d = rneg_q ? (~step[2*WIDTH-1:WIDTH] + 1'b1) : step[2*WIDTH-1:WIDTH];
               end else begin
                  hi_d = mul_fix[2*WIDTH-1:WIDTH];
                  lo_d = mul_fix[WIDTH-1:0];
               end
`else
               hi_d = mul_fix[2*WIDTH-1:WIDTH];
               lo_d = mul_fix[WIDTH-1:0];
`endif
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         work_q  <= '0;
         opnd_q  <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         neg_q   <= 1'b0;
         dbz_q   <= 1'b0;
`ifdef MULDIV_DIV_EN
         div_q   <= 1'b0;
         rneg_q  <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         work_q  <= work_d;
         opnd_q  <= opnd_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         neg_q   <= neg_d;
         dbz_q   <= dbz_d;
`ifdef MULDIV_DIV_EN
         div_q   <= div_d;
         rneg_q  <= rneg_d;
`endif
      end
   end

   assign div_by_zero = dbz_q;
   assign md_result   = reset ? '0 : ((fn == FN_MFHI) ? hi_q : lo_q);

endmodule

// File: tb/tb_muldiv_alu_control.sv
module tb_muldiv_alu_control;

   localparam int W = 32;

   localparam logic [5:0] F_MFHI  = 6'b010000;
   localparam logic [5:0] F_MTHI  = 6'b010001;
   localparam logic [5:0] F_MFLO  = 6'b010010;
   localparam logic [5:0] F_MTLO  = 6'b010011;
   localparam logic [5:0] F_MULT  = 6'b011000;
   localparam logic [5:0] F_MULTU = 6'b011001;
   localparam logic [5:0] F_DIV   = 6'b011010;
   localparam logic [5:0] F_DIVU  = 6'b011011;

   logic          clk = 1'b0;
   logic          reset;
   logic [1:0]    alu_op;
   logic [5:0]    func_field;
   logic          valid;
   logic [W-1:0]  operand_a, operand_b;
   logic [3:0]    operation;
   logic [W-1:0]  md_result;
   logic          md_busy, stall, div_by_zero;

   int n_cmp = 0;
   int n_err = 0;

   muldiv_alu_control #(.WIDTH(W), .FUNC_W(6)) dut (
      .clk        (clk),
      .reset      (reset),
      .alu_op     (alu_op),
      .func_field (func_field),
      .valid      (valid),
      .operand_a  (operand_a),
      .operand_b  (operand_b),
      .operation  (operation),
      .md_result  (md_result),
      .md_busy    (md_busy),
      .stall      (stall),
      .div_by_zero(div_by_zero)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic dec(input string tag, input logic [1:0] op, input logic [5:0] f,
                      input logic [3:0] exp);
      alu_op = op; func_field = f; valid = 1'b0;
      #1;
      chk(tag, {60'd0, operation}, {60'd0, exp});
   endtask

   // present one md instruction for a single edge, then drop valid
   task automatic issue(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
      alu_op = 2'b10; func_field = f; valid = 1'b1;
      operand_a = a; operand_b = b;
      #1;
      chk("issue_no_stall", {63'd0, stall}, 64'd0);
      tick();
      valid = 1'b0;
   endtask

   // counts cycles md_busy is seen high after the issue edge (bounded)
   task automatic wait_idle(output int cyc);
      cyc = 0;
      while (md_busy && cyc < 200) begin
         cyc++;
         tick();
      end
   endtask

   task automatic rd(input logic [5:0] f, output logic [W-1:0] r);
      alu_op = 2'b10; func_field = f; valid = 1'b0;
      #1;
      r = md_result;
   endtask

   logic [W-1:0] r;
   int           cyc;

   initial begin
      reset = 1'b1; alu_op = 2'b00; func_field = F_MFHI; valid = 1'b0;
      operand_a = '0; operand_b = '0;
      #2;
      chk("rst_busy", {63'd0, md_busy}, 64'd0);
      chk("rst_dbz", {63'd0, div_by_zero}, 64'd0);
      chk("rst_md_result", {32'd0, md_result}, 64'd0);
      tick(); tick();
      reset = 1'b0;
      rd(F_MFHI, r); chk("rst_hi", {32'd0, r}, 64'd0);
      rd(F_MFLO, r); chk("rst_lo", {32'd0, r}, 64'd0);

      // ALU decode
      dec("dec_sub",   2'b10, 6'b100010, 4'b0110);
      dec("dec_slt",   2'b10, 6'b101010, 4'b0111);
      dec("dec_nor",   2'b10, 6'b100111, 4'b1100);
      dec("dec_op00",  2'b00, 6'b100010, 4'b0010);
      dec("dec_op01",  2'b01, 6'b000000, 4'b0110);
      dec("dec_f0",    2'b10, 6'b000000, 4'b0010);
      dec("dec_and",   2'b10, 6'b100100, 4'b0000);
      dec("dec_sltu",  2'b10, 6'b101011, 4'b1000);
      dec("dec_mflo",  2'b10, F_MFLO,    4'b1111);
      dec("dec_op11",  2'b11, 6'b101010, 4'b0010);
      dec("dec_mult",  2'b10, F_MULT,    4'b0010);

      // MULT -3 * 7 = -21
      issue(F_MULT, 32'hFFFF_FFFD, 32'd7);
      wait_idle(cyc);
      chk("mult_busy_cycles", 64'(cyc), 64'd32);
      rd(F_MFHI, r); chk("mult_hi", {32'd0, r}, 64'hFFFF_FFFF);
      rd(F_MFLO, r); chk("mult_lo", {32'd0, r}, 64'hFFFF_FFEB);

      // MULTU FFFFFFFF * 2 = 1_FFFFFFFE
      issue(F_MULTU, 32'hFFFF_FFFF, 32'd2);
      wait_idle(cyc);
      chk("multu_busy_cycles", 64'(cyc), 64'd32);
      rd(F_MFHI, r); chk("multu_hi", {32'd0, r}, 64'd1);
      rd(F_MFLO, r); chk("multu_lo", {32'd0, r}, 64'hFFFF_FFFE);

      // MULT 6*7, one bubble, then MFLO waits for the remaining 31 busy cycles
      issue(F_MULT, 32'd6, 32'd7);
      tick();
      alu_op = 2'b10; func_field = F_MFLO; valid = 1'b1;
      #1;
      cyc = 0;
      while (stall && cyc < 200) begin
         cyc++;
         tick();
      end
      chk("mflo_stall_cycles", 64'(cyc), 64'd31);
      chk("mflo_after_stall", {32'd0, md_result}, 64'd42);
      tick();
      valid = 1'b0;

      // MTHI / MTLO visible the next cycle
      issue(F_MTHI, 32'h0000_ABCD, 32'd0);
      rd(F_MFHI, r); chk("mthi", {32'd0, r}, 64'h0000_ABCD);
      issue(F_MTLO, 32'd1234, 32'd0);
      rd(F_MFLO, r); chk("mtlo", {32'd0, r}, 64'd1234);
      chk("mtlo_no_busy", {63'd0, md_busy}, 64'd0);

      // reset in the middle of a RUN
      issue(F_MULT, 32'd3, 32'd5);
      for (int i = 0; i < 9; i++) tick();
      chk("midrun_busy_before", {63'd0, md_busy}, 64'd1);
      reset = 1'b1;
      #1;
      chk("midrun_busy", {63'd0, md_busy}, 64'd0);
      chk("midrun_md_result", {32'd0, md_result}, 64'd0);
      chk("midrun_dbz", {63'd0, div_by_zero}, 64'd0);
      reset = 1'b0;
      rd(F_MFLO, r); chk("midrun_lo", {32'd0, r}, 64'd0);
      rd(F_MFHI, r); chk("midrun_hi", {32'd0, r}, 64'd0);
      tick();
      issue(F_MULT, 32'd3, 32'd5);
      wait_idle(cyc);
      chk("post_rst_busy_cycles", 64'(cyc), 64'd32);
      rd(F_MFLO, r); chk("post_rst_lo", {32'd0, r}, 64'd15);
      rd(F_MFHI, r); chk("post_rst_hi", {32'd0, r}, 64'd0);

`ifdef MULDIV_DIV_EN
      // DIVU 100/7, MFLO after one bubble
      issue(F_DIVU, 32'd100, 32'd7);
      tick();
      alu_op = 2'b10; func_field = F_MFLO; valid = 1'b1;
      #1;
      cyc = 0;
      while (stall && cyc < 200) begin
         cyc++;
         tick();
      end
      chk("divu_stall_cycles", 64'(cyc), 64'd31);
      chk("divu_lo", {32'd0, md_result}, 64'd14);
      valid = 1'b0;
      rd(F_MFHI, r); chk("divu_hi", {32'd0, r}, 64'd2);

      // DIV -7/2 = -3 rem -1
      issue(F_DIV, 32'hFFFF_FFF9, 32'd2);
      wait_idle(cyc);
      chk("div_busy_cycles", 64'(cyc), 64'd32);
      rd(F_MFLO, r); chk("div_neg_lo", {32'd0, r}, 64'hFFFF_FFFD);
      rd(F_MFHI, r); chk("div_neg_hi", {32'd0, r}, 64'hFFFF_FFFF);

      // most-negative / -1
      issue(F_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
      wait_idle(cyc);
      rd(F_MFLO, r); chk("div_ovf_lo", {32'd0, r}, 64'h8000_0000);
      rd(F_MFHI, r); chk("div_ovf_hi", {32'd0, r}, 64'd0);

      // divide by zero: fixed result at the issue edge, one-cycle pulse
      issue(F_DIV, 32'd5, 32'd0);
      chk("dbz_pulse", {63'd0, div_by_zero}, 64'd1);
      chk("dbz_no_busy", {63'd0, md_busy}, 64'd0);
      tick();
      chk("dbz_pulse_end", {63'd0, div_by_zero}, 64'd0);
      rd(F_MFHI, r); chk("dbz_hi", {32'd0, r}, 64'd5);
      rd(F_MFLO, r); chk("dbz_lo", {32'd0, r}, 64'hFFFF_FFFF);
`else
      // divide disabled: DIV/DIVU are plain ADDs and leave HI/LO alone
      issue(F_MTHI, 32'd55, 32'd0);
      issue(F_MTLO, 32'd66, 32'd0);
      dec("dec_div", 2'b10, F_DIV, 4'b0010);
      issue(F_DIV, 32'd5, 32'd0);
      chk("nodiv_dbz", {63'd0, div_by_zero}, 64'd0);
      chk("nodiv_busy", {63'd0, md_busy}, 64'd0);
      issue(F_DIVU, 32'd100, 32'd7);
      chk("nodivu_busy", {63'd0, md_busy}, 64'd0);
      rd(F_MFHI, r); chk("nodiv_hi", {32'd0, r}, 64'd55);
      rd(F_MFLO, r); chk("nodiv_lo", {32'd0, r}, 64'd66);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
